// File: rtl/pe_boundary_feeder.sv
// Read-side feeder between systolic passes: pass 0 emits constant boundary tuples,
// later passes replay delay-line tuples from a small FIFO into PE column 0.
module pe_boundary_feeder #(
  parameter int W          = 12,
  parameter int ROW_NUM    = 128,
  parameter int PASS_NUM   = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int RW = $clog2(ROW_NUM),
  localparam int PW = $clog2(PASS_NUM),
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [W-1:0]  max_in,
  input  logic [W-1:0]  v_in,
  input  logic [W-1:0]  f_in,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  max_out,
  output logic [W-1:0]  v_out,
  output logic [W-1:0]  f_out,
  output logic [RW-1:0] row_idx,
  output logic [PW-1:0] pass_idx,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  best_max,
  output logic          overflow
);

  typedef struct packed {
    logic [W-1:0] mx;
    logic [W-1:0] v;
    logic [W-1:0] f;
  } tuple_t;

  typedef enum logic [1:0] {IDLE, INIT, FWD, DONE} state_t;

  localparam tuple_t         INIT_T    = {{W{1'b0}}, {W{1'b0}}, W'(-4)};
  localparam logic [RW-1:0]  ROW_LAST  = RW'(ROW_NUM - 1);
  localparam logic [PW-1:0]  PASS_LAST = PW'(PASS_NUM - 1);
  localparam logic [AW:0]    DEPTH     = (AW+1)'(FIFO_DEPTH);

  state_t        state, state_nx;
  tuple_t        mem [FIFO_DEPTH];
  tuple_t        out_q, in_t;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          full, empty, active, start_go;
  logic          push, pop, xfer, last_row, last_pass, fin;

  assign in_t      = {max_in, v_in, f_in};
  assign full      = (count == DEPTH);
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign active    = (state == INIT) || (state == FWD);
  assign start_go  = (state == IDLE) && start;
  assign push      = in_valid && !full && active;
  assign xfer      = out_valid && out_ready;
  assign last_row  = (row_idx == ROW_LAST);
  assign last_pass = (pass_idx == PASS_LAST);
  assign fin       = (state == FWD) && xfer && last_row && last_pass;
  // The last pass-0 transfer pulls the FIFO head straight in, so pass 1 starts without a bubble.
  assign pop       = !empty && (((state == FWD) && (!out_valid || xfer) && !fin) ||
                                ((state == INIT) && xfer && last_row));

  assign busy    = active;
  assign done    = (state == DONE);
  assign max_out = out_q.mx;
  assign v_out   = out_q.v;
  assign f_out   = out_q.f;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_go) state_nx = INIT;
      INIT:    if (xfer && last_row) state_nx = FWD;
      FWD:     if (fin) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_t;
  end

  // Leftover tuples are discarded on completion; start also clears any stale contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (start_go || state == DONE) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_q     <= INIT_T;
    end else if (start_go) begin
      out_valid <= 1'b1;
      out_q     <= INIT_T;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_q     <= mem[rptr];
    end else if (state == DONE || (xfer && (state == FWD || last_row))) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_idx  <= '0;
      pass_idx <= '0;
    end else if (start_go) begin
      row_idx  <= '0;
      pass_idx <= '0;
    end else if (active && xfer) begin
      if (last_row) begin
        row_idx <= '0;
        if (!fin) pass_idx <= pass_idx + PW'(1);
      end else begin
        row_idx <= row_idx + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      best_max <= '0;
      overflow <= 1'b0;
    end else if (start_go) begin
      best_max <= '0;
      overflow <= 1'b0;
    end else begin
      if (state == FWD && xfer && $signed(max_out) > $signed(best_max)) best_max <= max_out;
      if (active && in_valid && full) overflow <= 1'b1;
    end
  end

endmodule
